// File: rtl/adc_capture_writer_pkg.sv
// ---------------------------------------------------------------------------
// adc_capture_writer_pkg
// Shared definitions for the ping-pong buffer write side:
//   - writerState_t : capture FSM encoding (IDLE=0, ARM=1, WRITE=2, DRAIN=3)
//   - WRITER_DATA_WIDTH   : default ADC sample width
//   - WRITER_BUFFER_WORDS : default words per ping/pong buffer (power of two)
// ---------------------------------------------------------------------------
package adc_capture_writer_pkg;

    localparam int WRITER_DATA_WIDTH   = 10;
    localparam int WRITER_BUFFER_WORDS = 8192;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        WRITE = 2'd2,
        DRAIN = 2'd3
    } writerState_t;

endpackage

// File: rtl/adc_capture_writer_sync_bit.sv
// ---------------------------------------------------------------------------
// sync_bit
// Multi-flop synchroniser for one asynchronous control bit.
// Ports:
//   clock   - destination clock
//   nReset  - asynchronous, active-low clear of every stage
//   asyncIn - asynchronous input bit
//   syncOut - synchronised bit (last stage)
// Parameter SYNC_STAGES sets the number of flops (>= 1).
// ---------------------------------------------------------------------------
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic nReset,
    input  logic asyncIn,
    output logic syncOut
);

    logic [SYNC_STAGES-1:0] stages;

    // Shift chain: stage 0 samples the asynchronous input.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            stages <= {SYNC_STAGES{1'b0}};
        end else begin
            stages[0] <= asyncIn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign syncOut = stages[SYNC_STAGES-1];

endmodule

// File: rtl/adc_capture_writer.sv
// ---------------------------------------------------------------------------
// adc_capture_writer
// Write-side producer for the ping-pong sample buffer. Registers ADC samples
// (or a test ramp) and drives dataIn/isWriting. Capture starts and stops only
// on whole-buffer boundaries.
// Ports:
//   nReset         - asynchronous active-low reset
//   writeClock     - ADC sample clock
//   collectData    - asynchronous host capture request
//   testMode       - asynchronous ramp select (ADC_TEST_PATTERN_EN builds only)
//   adcData        - raw ADC sample
//   bufferOverflow - overflow flag from the buffer (writeClock domain)
//   dataIn         - sample to buffer (registered)
//   isWriting      - write strobe, one word per high cycle (registered)
//   bufferCount    - completed buffers this run, wraps
//   overflowCount  - overflow rising edges this run, saturating
//   captureActive  - high while in ARM, WRITE or DRAIN (registered)
// Optional feature macro: ADC_TEST_PATTERN_EN (test ramp generator).
// ---------------------------------------------------------------------------
module adc_capture_writer
    import adc_capture_writer_pkg::*;
#(
    parameter int DATA_WIDTH   = WRITER_DATA_WIDTH,
    parameter int BUFFER_WORDS = WRITER_BUFFER_WORDS,
    parameter int SYNC_STAGES  = 2,
    parameter int PIPE_DEPTH   = 2
) (
    input  logic                  nReset,
    input  logic                  writeClock,
    input  logic                  collectData,
    input  logic                  testMode,
    input  logic [DATA_WIDTH-1:0] adcData,
    input  logic                  bufferOverflow,
    output logic [DATA_WIDTH-1:0] dataIn,
    output logic                  isWriting,
    output logic [15:0]           bufferCount,
    output logic [15:0]           overflowCount,
    output logic                  captureActive
);

    localparam int WC_W  = $clog2(BUFFER_WORDS);
    localparam int ARM_W = $clog2(PIPE_DEPTH + 1);
    localparam logic [WC_W-1:0] WC_ZERO   = {WC_W{1'b0}};
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(BUFFER_WORDS - 1);

    writerState_t          state;
    writerState_t          nextState;
    logic                  collectSync;
    logic                  issue;      // isWriting value for the next cycle
    logic                  startRun;   // IDLE -> ARM transition
    logic [WC_W-1:0]       wordCount;  // words issued in the current buffer
    logic [ARM_W-1:0]      armCnt;
    logic [DATA_WIDTH-1:0] adcPipeRegs [PIPE_DEPTH];
    logic [DATA_WIDTH-1:0] adcPipe;
    logic [DATA_WIDTH-1:0] sampleSel;
    logic                  ovfPrev;
    logic                  ovfRise;

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) collectSyncInst (
        .clock   (writeClock),
        .nReset  (nReset),
        .asyncIn (collectData),
        .syncOut (collectSync)
    );

`ifdef ADC_TEST_PATTERN_EN
    logic                  testSync;
    logic                  testLatched;
    logic [DATA_WIDTH-1:0] ramp;

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) testSyncInst (
        .clock   (writeClock),
        .nReset  (nReset),
        .asyncIn (testMode),
        .syncOut (testSync)
    );

    // Ramp source: mode frozen at run start, ramp advances per issued word.
    always_ff @(posedge writeClock or negedge nReset) begin
        if (!nReset) begin
            testLatched <= 1'b0;
            ramp        <= {DATA_WIDTH{1'b0}};
        end else if (startRun) begin
            testLatched <= testSync;
            ramp        <= {DATA_WIDTH{1'b0}};
        end else if (issue) begin
            ramp <= ramp + DATA_WIDTH'(1);
        end
    end

    assign sampleSel = testLatched ? ramp : adcPipe;
`else
    // Without the ramp generator the test mode select has no function.
    logic unusedTestMode;
    assign unusedTestMode = testMode;
    assign sampleSel      = adcPipe;
`endif

    // ADC input register chain.
    always_ff @(posedge writeClock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                adcPipeRegs[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            adcPipeRegs[0] <= adcData;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                adcPipeRegs[i] <= adcPipeRegs[i-1];
            end
        end
    end

    assign adcPipe = adcPipeRegs[PIPE_DEPTH-1];

    // Next-state and word-issue decision. wordCount==0 means every word
    // issued so far closes a whole buffer, so stopping there is clean.
    always_comb begin
        nextState = state;
        issue     = 1'b0;
        startRun  = 1'b0;
        case (state)
            IDLE: begin
                if (collectSync) begin
                    nextState = ARM;
                    startRun  = 1'b1;
                end else begin
                    nextState = IDLE;
                end
            end
            ARM: begin
                if (!collectSync) begin
                    nextState = IDLE;
                end else if (armCnt == ARM_W'(1)) begin
                    nextState = WRITE;
                end else begin
                    nextState = ARM;
                end
            end
            WRITE: begin
                if (!collectSync && (wordCount == WC_ZERO)) begin
                    nextState = IDLE;
                end else if (!collectSync) begin
                    nextState = DRAIN;
                    issue     = 1'b1;
                end else begin
                    nextState = WRITE;
                    issue     = 1'b1;
                end
            end
            DRAIN: begin
                if (collectSync) begin
                    nextState = WRITE;
                    issue     = 1'b1;
                end else if (wordCount == WC_ZERO) begin
                    nextState = IDLE;
                end else begin
                    nextState = DRAIN;
                    issue     = 1'b1;
                end
            end
            default: begin
                nextState = IDLE;
                issue     = 1'b0;
            end
        endcase
    end

    // State register and registered buffer interface.
    always_ff @(posedge writeClock or negedge nReset) begin
        if (!nReset) begin
            state         <= IDLE;
            isWriting     <= 1'b0;
            dataIn        <= {DATA_WIDTH{1'b0}};
            captureActive <= 1'b0;
        end else begin
            state         <= nextState;
            isWriting     <= issue;
            dataIn        <= sampleSel;
            captureActive <= (nextState != IDLE);
        end
    end

    // Arm delay lets the ADC pipeline fill before the first word.
    always_ff @(posedge writeClock or negedge nReset) begin
        if (!nReset) begin
            armCnt <= {ARM_W{1'b0}};
        end else if (startRun) begin
            armCnt <= ARM_W'(PIPE_DEPTH);
        end else if (state == ARM) begin
            armCnt <= armCnt - ARM_W'(1);
        end
    end

    // Word and completed-buffer counters, advanced as each word is issued.
    always_ff @(posedge writeClock or negedge nReset) begin
        if (!nReset) begin
            wordCount   <= WC_ZERO;
            bufferCount <= 16'd0;
        end else if (startRun) begin
            wordCount   <= WC_ZERO;
            bufferCount <= 16'd0;
        end else if (issue) begin
            wordCount <= wordCount + WC_W'(1);
            if (wordCount == LAST_WORD) begin
                bufferCount <= bufferCount + 16'd1;
            end
        end
    end

    assign ovfRise = bufferOverflow & ~ovfPrev;

    // Overflow edge counter; the edge register runs even while idle.
    always_ff @(posedge writeClock or negedge nReset) begin
        if (!nReset) begin
            ovfPrev       <= 1'b0;
            overflowCount <= 16'd0;
        end else begin
            ovfPrev <= bufferOverflow;
            if (startRun) begin
                overflowCount <= 16'd0;
            end else if (ovfRise && captureActive && (overflowCount != 16'hFFFF)) begin
                overflowCount <= overflowCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_writer.sv
module tb_adc_capture_writer;

    localparam int DW = 10;
    localparam int BW = 8192;

    logic          nReset = 1'b1;
    logic          writeClock = 1'b0;
    logic          collectData = 1'b0;
    logic          testMode = 1'b0;
    logic          bufferOverflow = 1'b0;
    logic [DW-1:0] adcData = '0;
    logic [DW-1:0] dataIn;
    logic          isWriting;
    logic [15:0]   bufferCount;
    logic [15:0]   overflowCount;
    logic          captureActive;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wordsSeen = 0;
    int expQ[$];
    int expVal;

    adc_capture_writer #(
        .DATA_WIDTH(DW), .BUFFER_WORDS(BW), .SYNC_STAGES(2), .PIPE_DEPTH(2)
    ) dut (
        .nReset(nReset), .writeClock(writeClock), .collectData(collectData),
        .testMode(testMode), .adcData(adcData), .bufferOverflow(bufferOverflow),
        .dataIn(dataIn), .isWriting(isWriting), .bufferCount(bufferCount),
        .overflowCount(overflowCount), .captureActive(captureActive)
    );

    always #5 writeClock = ~writeClock;

    always @(posedge writeClock) cyc <= cyc + 1;

    // ADC stimulus: the sample presented during cycle c is c mod 1024.
    initial forever begin
        @(posedge writeClock);
        #1;
        adcData = cyc[DW-1:0];
    end

    // Monitor: every written word is compared with the scoreboard head.
    always @(negedge writeClock) begin
        if (nReset && isWriting) begin
            wordsSeen++;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL unexpectedWrite: dataIn=%0d written, expected no write", dataIn);
            end else begin
                expVal = expQ.pop_front();
                if (int'(dataIn) != expVal) begin
                    errors++;
                    $display("FAIL dataIn[word %0d]: got %0d, expected %0d", wordsSeen, dataIn, expVal);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge writeClock);
        #1;
    endtask

    // First word of a run raised in cycle r is the sample of cycle r+3
    // (2 sync flops + 1 state edge + 2 arm cycles vs 2 pipe stages + 1 reg).
    task automatic pushAdc(input int r, input int n);
        for (int k = 0; k < n; k++) expQ.push_back((r + 3 + k) & 1023);
    endtask

    task automatic pushRamp(input int n);
        for (int k = 0; k < n; k++) expQ.push_back(k & 1023);
    endtask

    task automatic waitIdle(input int maxCycles, input string name);
        int n;
        n = 0;
        while (captureActive && n < maxCycles) begin
            tick(1);
            n++;
        end
        check(name, int'(captureActive), 0);
    endtask

    initial begin
        int r;
        int base;
        int n;
        int activeCycles;
        int writes;
        int firstRise;

        // Reset state
        #2;
        nReset = 1'b0;
        tick(2);
        check("reset_isWriting", int'(isWriting), 0);
        check("reset_dataIn", int'(dataIn), 0);
        check("reset_bufferCount", int'(bufferCount), 0);
        check("reset_overflowCount", int'(overflowCount), 0);
        check("reset_captureActive", int'(captureActive), 0);
        nReset = 1'b1;
        tick(5);

        // Run A: long capture with overflow pulses, ends on 4 whole buffers
        base = wordsSeen;
        r = cyc;
        collectData = 1'b1;
        pushAdc(r, 4 * BW);
        tick(500);
        repeat (3) begin
            bufferOverflow = 1'b1;
            tick(1000);
            bufferOverflow = 1'b0;
            tick(1000);
        end
        tick(3 * BW + 100 - 6500);
        collectData = 1'b0;
        waitIdle(2 * BW, "runA_idle");
        check("runA_words", wordsSeen - base, 4 * BW);
        check("runA_bufferCount", int'(bufferCount), 4);
        check("runA_overflowCount", int'(overflowCount), 3);
        check("runA_isWriting", int'(isWriting), 0);
        check("runA_queueLeft", expQ.size(), 0);

        // Run B: one-cycle collect pulse reaches ARM then aborts
        tick(5);
        collectData = 1'b1;
        tick(1);
        collectData = 1'b0;
        activeCycles = 0;
        writes = 0;
        firstRise = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge writeClock);
            if (captureActive) begin
                activeCycles++;
                if (firstRise < 0) firstRise = i + 1;
            end
            if (isWriting) writes++;
        end
        check("pulse_riseDelay", firstRise, 3);
        check("pulse_activeCycles", activeCycles, 1);
        check("pulse_writes", writes, 0);
        check("pulse_bufferCountCleared", int'(bufferCount), 0);
        check("pulse_overflowCountCleared", int'(overflowCount), 0);
        tick(1);
        check("pulse_idle", int'(captureActive), 0);

        // Run C: test mode run, mid-run toggle, level overflow, reset in DRAIN
        testMode = 1'b1;
        tick(5);
        base = wordsSeen;
        r = cyc;
        collectData = 1'b1;
`ifdef ADC_TEST_PATTERN_EN
        pushRamp(5000);
`else
        pushAdc(r, 5000);
`endif
        tick(300);
        bufferOverflow = 1'b1;
        tick(300);
        testMode = 1'b0;
        tick(600);
        collectData = 1'b0;
        tick(1100);
        check("level_overflowCount", int'(overflowCount), 1);
        check("drain_active", int'(captureActive), 1);
        bufferOverflow = 1'b0;
        n = 0;
        while ((wordsSeen - base) < 5000 && n < 10000) begin
            @(negedge writeClock);
            #1;
            n++;
        end
        check("runC_wordsBeforeReset", wordsSeen - base, 5000);
        nReset = 1'b0;
        #1;
        check("midReset_isWriting", int'(isWriting), 0);
        check("midReset_dataIn", int'(dataIn), 0);
        check("midReset_bufferCount", int'(bufferCount), 0);
        check("midReset_overflowCount", int'(overflowCount), 0);
        check("midReset_captureActive", int'(captureActive), 0);
        check("runC_queueLeft", expQ.size(), 0);
        expQ.delete();
        tick(3);
        nReset = 1'b1;
        tick(5);

        // Run D: fresh run after reset writes exactly one buffer
        base = wordsSeen;
        r = cyc;
        collectData = 1'b1;
        pushAdc(r, BW);
        tick(100);
        collectData = 1'b0;
        waitIdle(2 * BW, "runD_idle");
        check("runD_words", wordsSeen - base, BW);
        check("runD_bufferCount", int'(bufferCount), 1);
        check("runD_overflowCount", int'(overflowCount), 0);
        check("runD_queueLeft", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_capture_writer.md
Name: adc_capture_writer

Overview:
Write-side producer for the ping-pong sample buffer. Registers 10-bit ADC samples, or a test ramp, on writeClock and drives the buffer's dataIn/isWriting pair. Synchronises the host collect request and starts and stops capture only on whole-buffer boundaries, so the buffer never holds a partial buffer. Counts completed buffers and overflow events for status reporting.

Parameters:
DATA_WIDTH, 10, sample width.
BUFFER_WORDS, 8192, words per ping/pong buffer; must be a power of two.
SYNC_STAGES, 2, flip-flop stages on each asynchronous control input.
PIPE_DEPTH, 2, ADC input register stages.

Ports:
nReset  input  1  asynchronous, active-low reset.
writeClock  input  1  ADC sample clock; all logic runs on this clock.
collectData  input  1  asynchronous host request to capture.
testMode  input  1  asynchronous; selects test ramp instead of ADC data.
adcData  input  DATA_WIDTH  raw ADC sample.
bufferOverflow  input  1  overflow flag from buffer, writeClock domain, held high about 1000 cycles.
dataIn  output  DATA_WIDTH  sample to buffer.
isWriting  output  1  write strobe to buffer, one word per high cycle.
bufferCount  output  16  completed buffers this run, wraps.
overflowCount  output  16  overflow events this run, saturating.
captureActive  output  1  high in ARM, WRITE and DRAIN.

Behaviour:
- Reset (async): state=IDLE; isWriting=0; dataIn=0; bufferCount=0; overflowCount=0; captureActive=0; wordCount=0; ramp=0; all sync and pipeline stages cleared. Assertion mid-run aborts immediately; no drain.
- collectData and testMode each pass through SYNC_STAGES flops, giving collectSync and testSync.
- ADC path: adcData passes through PIPE_DEPTH registers to adcPipe. A sample presented before edge N is on adcPipe after edge N+PIPE_DEPTH-1.
- wordCount: log2(BUFFER_WORDS) bits. Increments on every cycle isWriting=1, wraps BUFFER_WORDS-1 to 0. When it wraps, bufferCount increments (mod 2^16).
- isWriting and dataIn are registered. dataIn = testLatched ? ramp : adcPipe.
- State machine (2-bit):
  - IDLE: isWriting=0. If collectSync=1: go to ARM, clear bufferCount, overflowCount, wordCount and ramp, latch testLatched<=testSync, load armCnt=PIPE_DEPTH.
  - ARM: isWriting=0; armCnt decrements each cycle. If collectSync=0: go to IDLE. If armCnt==1: go to WRITE.
  - WRITE: isWriting=1 every cycle. If collectSync=0 and wordCount==0: go to IDLE (already on a boundary, zero extra words). If collectSync=0 and wordCount!=0: go to DRAIN.
  - DRAIN: isWriting=1 until the word at wordCount=BUFFER_WORDS-1 has been written, then go to IDLE. isWriting=0 from the next cycle. If collectSync returns to 1: go back to WRITE with no gap in isWriting.
- Total words per run is always a multiple of BUFFER_WORDS.
- ramp: DATA_WIDTH-bit counter, advances on each written word, wraps 1023 to 0. testLatched is frozen for the run; toggling testMode mid-run has no effect.
- overflowCount increments on each 0-to-1 edge of bufferOverflow (edge register, not level) and saturates at 0xFFFF. The edge detector keeps running in IDLE; the count only increments while captureActive=1.
- captureActive = (state != IDLE), registered.

Optional Feature:
ADC_TEST_PATTERN_EN.
- Defined: ramp generator present; testMode behaves as above.
- Undefined: ramp logic is not instantiated, testLatched is tied to 0, testMode is ignored, and dataIn always equals adcPipe.

Decomposition:
- Shared package: writer state encoding (IDLE=0, ARM=1, WRITE=2, DRAIN=3), BUFFER_WORDS, DATA_WIDTH.
- One sub-module, sync_bit: a SYNC_STAGES flop synchroniser with async active-low clear. It is instantiated for collectData and for testMode.

Test Plan:
- Reset, then collectData=1 for 3*8192+100 cycles, then 0 → isWriting falls exactly after 4*8192 words; bufferCount=4; state returns to IDLE.
- collectData pulse of 1 cycle → at least SYNC_STAGES flop delay, then ARM; collectSync drops, so ARM returns to IDLE with isWriting never high.
- testMode=1 with ADC_TEST_PATTERN_EN → dataIn sequence 0,1,…,1023,0,… from the first isWriting; toggling testMode mid-run leaves the sequence unchanged.
- ADC ramp input (value = cycle index) → dataIn on the first write cycle equals the sample presented PIPE_DEPTH cycles earlier plus one register; no samples skipped or repeated.
- bufferOverflow pulses 3 times (each 1000 cycles high) during WRITE → overflowCount=3; a level held high → count 1.
- nReset asserted in DRAIN at wordCount=5000 → isWriting=0, all counts 0 immediately; after release, a new run starts with wordCount=0.
